my_dmaster: RTL

- Avalon-MM write master: the initiator side of the 8-bit write-only slave path in the Lab4 system.
- Accepts bytes on a conduit valid/ready input and buffers them in a small FIFO.
- Issues one Avalon-MM write per byte to an incrementing address window, honouring waitrequest.
- Exposes completed-write count and sticky overflow flag on the conduit.

---
 rtl/my_dmaster_if.sv | 39 +++
 rtl/my_dmaster.sv | 124 ++++++++++++
 2 files changed

// File: rtl/my_dmaster_if.sv
// Bus bundle for my_dmaster: Avalon-MM write-master signals plus the byte-input conduit.
// The master modport is the DMA side; the slave modport is the fabric/source side.
interface my_dmaster_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [ADDR_W-1:0] avm_m0_address;
  logic              avm_m0_write;
  logic [7:0]        avm_m0_writedata;
  logic              avm_m0_waitrequest;
  logic [7:0]        coe_m0_Din;
  logic              coe_m0_valid;
  logic              coe_m0_ready;
  logic [7:0]        coe_m0_count;
  logic              coe_m0_overflow;

  modport master (
    output avm_m0_address,
    output avm_m0_write,
    output avm_m0_writedata,
    input  avm_m0_waitrequest,
    input  coe_m0_Din,
    input  coe_m0_valid,
    output coe_m0_ready,
    output coe_m0_count,
    output coe_m0_overflow
  );

  modport slave (
    input  avm_m0_address,
    input  avm_m0_write,
    input  avm_m0_writedata,
    output avm_m0_waitrequest,
    output coe_m0_Din,
    output coe_m0_valid,
    input  coe_m0_ready,
    input  coe_m0_count,
    input  coe_m0_overflow
  );
endinterface

// File: rtl/my_dmaster.sv
// Avalon-MM byte write master: buffers conduit bytes in a small FIFO and writes each one to
// an incrementing, wrapping address window, honouring waitrequest.
module my_dmaster #(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       NUM_WORDS  = 16,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input logic          csi_clk,
  input logic          rsi_reset,
  my_dmaster_if.master bus
);
  localparam int unsigned OffW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OffW-1:0] OffLast = OffW'(NUM_WORDS - 1);
  localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);

  typedef enum logic {StIdle, StWrite} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]   occ_q, occ_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [OffW-1:0]   offset_q, offset_d, offset_inc;
  logic [7:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              ready, push, pop;

  // Ready reflects occupancy before the edge, so a full FIFO rejects even on a pop edge.
  assign ready      = (occ_q != OccFull);
  assign push       = bus.coe_m0_valid && ready;
  assign offset_inc = (offset_q == OffLast) ? '0 : offset_q + OffW'(1);

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    data_d   = data_q;
    offset_d = offset_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (bus.coe_m0_valid & ~ready);
    pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        write_d = 1'b0;
        if (occ_q != '0) begin
          data_d  = mem_q[rd_ptr_q];
          addr_d  = BASE_ADDR + ADDR_W'(offset_q);
          write_d = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (!bus.avm_m0_waitrequest) begin
          pop      = 1'b1;
          count_d  = count_q + 8'd1;
          offset_d = offset_inc;
          // Next head is either already queued or bypassed from the byte arriving now.
          if (occ_q > OccW'(1) || push) begin
            data_d = (occ_q > OccW'(1)) ? mem_q[rd_ptr_q + PtrW'(1)] : bus.coe_m0_Din;
            addr_d = BASE_ADDR + ADDR_W'(offset_inc);
          end else begin
            write_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge csi_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.coe_m0_Din;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= BASE_ADDR;
      data_q   <= '0;
      offset_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      offset_q <= offset_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.avm_m0_address   = addr_q;
  assign bus.avm_m0_write     = write_q;
  assign bus.avm_m0_writedata = data_q;
  assign bus.coe_m0_ready     = ready;
  assign bus.coe_m0_count     = count_q;
  assign bus.coe_m0_overflow  = ovf_q;
endmodule
